// File: rtl/div16_8_seq_if.sv
// Operand/result handshake bundle for the sequential 2W/W unsigned divider.
interface div16_8_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   in_dividend;
  logic [WIDTH-1:0]     in_divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_quot;
  logic [WIDTH-1:0]     out_rem;
  logic                 out_dbz;
  logic                 out_ovf;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, in_dividend, in_divisor, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_dbz, out_ovf
  );

  // The divider itself.
  modport slave (
    input  in_valid, in_dividend, in_divisor, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_dbz, out_ovf
  );
endinterface

// File: rtl/div16_8_seq.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per clock, one operation in flight.
// Divide-by-zero and quotient overflow are resolved at acceptance.
module div16_8_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  div16_8_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state;
  // The partial remainder always stays below the divisor, so WIDTH bits hold it;
  // the extra bit only exists transiently in the trial value below.
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   dvd_sr;
  logic [WIDTH-1:0]   div_r;
  logic [WIDTH-1:0]   quo_sr;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH:0]     step_t;
  logic               step_ge;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic               accept;

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid && (state == IDLE);
  assign acc_hi       = bus.in_dividend[2*WIDTH-1:WIDTH];
  assign acc_lo       = bus.in_dividend[WIDTH-1:0];

  // One restoring step: shift in the next dividend bit and try a subtract.
  always_comb begin
    step_t   = {rem_r, dvd_sr[WIDTH-1]};
    step_ge  = (step_t >= {1'b0, div_r});
    step_rem = step_t[WIDTH-1:0];
    if (step_ge) begin
      step_rem = WIDTH'(step_t - {1'b0, div_r});
    end
    step_quo = {quo_sr[WIDTH-2:0], step_ge};
  end

  // Control FSM with registered result/flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rem_r         <= '0;
      dvd_sr        <= '0;
      div_r         <= '0;
      quo_sr        <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_quot  <= '0;
      bus.out_rem   <= '0;
      bus.out_dbz   <= 1'b0;
      bus.out_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            div_r <= bus.in_divisor;
            if (bus.in_divisor == '0) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.out_quot  <= '1;
              bus.out_rem   <= acc_lo;
              bus.out_dbz   <= 1'b1;
              bus.out_ovf   <= 1'b0;
            end else if (acc_hi >= bus.in_divisor) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.out_quot  <= '1;
              bus.out_rem   <= '0;
              bus.out_dbz   <= 1'b0;
              bus.out_ovf   <= 1'b1;
            end else begin
              state  <= BUSY;
              rem_r  <= acc_hi;
              dvd_sr <= acc_lo;
              quo_sr <= '0;
              cnt    <= '0;
            end
          end
        end

        BUSY: begin
          rem_r  <= step_rem;
          quo_sr <= step_quo;
          dvd_sr <= {dvd_sr[WIDTH-2:0], 1'b0};
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_quot  <= step_quo;
            bus.out_rem   <= step_rem;
            bus.out_dbz   <= 1'b0;
            bus.out_ovf   <= 1'b0;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div16_8_seq.sv
// Directed and randomised checks for the sequential 16/8 divider.
module tb_div16_8_seq;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  div16_8_seq_if #(.WIDTH(WIDTH)) bus ();

  div16_8_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and check latency and result; consumes it when out_ready=1.
  task automatic do_op(input logic [15:0] p, input logic [7:0] d,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic edbz, input logic eovf, input string tag);
    int unsigned w;
    int unsigned lat;
    w = 0;
    while (!bus.in_ready && w < 32) begin
      tick();
      w++;
    end
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid    = 1'b1;
    bus.in_dividend = p;
    bus.in_divisor  = d;
    tick();
    bus.in_valid    = 1'b0;
    bus.in_dividend = ~p;
    bus.in_divisor  = ~d;
    chk({tag, ".busy_ready"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), (edbz || eovf) ? 32'd0 : 32'(WIDTH));
    chk({tag, ".quot"}, 32'(bus.out_quot), 32'(eq));
    chk({tag, ".rem"}, 32'(bus.out_rem), 32'(er));
    chk({tag, ".dbz"}, 32'(bus.out_dbz), 32'(edbz));
    chk({tag, ".ovf"}, 32'(bus.out_ovf), 32'(eovf));
    if (!edbz && !eovf) begin
      chk({tag, ".invariant"}, 32'(bus.out_quot) * 32'(d) + 32'(bus.out_rem), 32'(p));
    end
    if (bus.out_ready) begin
      tick();
      chk({tag, ".drained"}, 32'(bus.out_valid), 32'd0);
      chk({tag, ".idle"}, 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    int unsigned seen;
    logic [15:0] rp;
    logic [7:0]  rd;
    logic [7:0]  mq;
    logic [7:0]  mr;
    logic        mdbz;
    logic        movf;

    passed          = 0;
    total           = 0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.out_ready   = 1'b1;

    // Reset state, observed before any clock edge.
    #2;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.quot", 32'(bus.out_quot), 32'd0);
    chk("rst.rem", 32'(bus.out_rem), 32'd0);
    chk("rst.flags", {30'd0, bus.out_dbz, bus.out_ovf}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed vectors.
    do_op(16'h3039, 8'h7B, 8'h64, 8'h2D, 1'b0, 1'b0, "normal");
    do_op(16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "maxq");
    do_op(16'hFFFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, "ovf");
    do_op(16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, "dbz");
    do_op(16'hFFFF, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, "dbz_prio");
    do_op(16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, "div1");
    do_op(16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, "zero");

    // Backpressure: result held while out_ready is low, in_valid ignored.
    bus.out_ready = 1'b0;
    do_op(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid    = 1'b1;
      bus.in_dividend = 16'h0101;
      bus.in_divisor  = 8'h02;
      tick();
      chk("bp.hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp.hold_quot", 32'(bus.out_quot), 32'h0E);
      chk("bp.hold_rem", 32'(bus.out_rem), 32'h02);
      chk("bp.hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp.released_valid", 32'(bus.out_valid), 32'd0);
    chk("bp.released_ready", 32'(bus.in_ready), 32'd1);
    chk("bp.data_kept", 32'(bus.out_quot), 32'h0E);
    tick();
    chk("bp.no_stray", 32'(bus.out_valid), 32'd0);

    // Reset in the 4th BUSY cycle aborts the operation.
    bus.in_valid    = 1'b1;
    bus.in_dividend = 16'h3039;
    bus.in_divisor  = 8'h7B;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort.in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort.data", {bus.out_quot, bus.out_rem, 14'd0, bus.out_dbz, bus.out_ovf}, 32'd0);
    tick();
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("abort.no_result", 32'(seen), 32'd0);
    do_op(16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0, "after_abort");

    // Random regression against a reference built on / and %.
    for (int i = 0; i < 400; i++) begin
      rd = 8'($urandom);
      if (i % 8 == 0) rd = 8'h00;
      if (i % 4 == 1 || rd == 8'h00) rp = 16'($urandom);
      else rp = {8'($urandom_range(0, int'(rd) - 1)), 8'($urandom)};
      mdbz = (rd == 8'h00);
      movf = !mdbz && (rp[15:8] >= rd);
      if (mdbz) begin
        mq = 8'hFF;
        mr = rp[7:0];
      end else if (movf) begin
        mq = 8'hFF;
        mr = 8'h00;
      end else begin
        mq = 8'(rp / 16'(rd));
        mr = 8'(rp % 16'(rd));
      end
      do_op(rp, rd, mq, mr, mdbz, movf, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
